// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out an amount of change, in 5-cent units, one coin at a time using
//   the fewest coins: quarters first, then dimes, then nickels.
//   Each coin is held on coin_valid/coin_type until the ejector acknowledges
//   it. A one-cycle gap separates consecutive coins. If the ejector does not
//   acknowledge within ACK_TIMEOUT cycles, the block locks in FAULT until
//   clear_n is asserted.
//
// Parameters
//   ACK_TIMEOUT : PRESENT cycles without coin_ack before FAULT (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   clear_n    in   synchronous active-low reset
//   start      in   begin a payout of 'amount' (sampled only in IDLE)
//   amount     in   [4:0] change owed in 5-cent units
//   coin_ack   in   ejector has taken the presented coin
//   coin_valid out  a coin request is presented
//   coin_type  out  [1:0] 00 nickel, 01 dime, 10 quarter
//   remaining  out  [4:0] units still owed, including the presented coin
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse when the payout completes
//   fault      out  sticky ejector-timeout flag
module change_dispenser #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [1:0] coin_type,
  output logic [4:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRESENT = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  // Largest coin that does not exceed the units owed, so the subtraction
  // below can never underflow.
  function automatic logic [1:0] coin_sel(input logic [4:0] units);
    logic [1:0] sel;
    if (units >= 5'd5) begin
      sel = 2'b10;
    end else if (units >= 5'd2) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Value of a coin type in 5-cent units.
  function automatic logic [4:0] coin_value(input logic [1:0] ctype);
    logic [4:0] val;
    case (ctype)
      2'b10:   val = 5'd5;
      2'b01:   val = 5'd2;
      2'b00:   val = 5'd1;
      default: val = 5'd1;
    endcase
    return val;
  endfunction

  // Declaration initialisers give the reset state before the first edge.
  logic [2:0] state_r      = IDLE;
  logic [4:0] remaining_r  = 5'd0;
  logic [7:0] wait_r       = 8'd0;
  logic       coin_valid_r = 1'b0;
  logic [1:0] coin_type_r  = 2'b00;
  logic       busy_r       = 1'b0;
  logic       done_r       = 1'b0;
  logic       fault_r      = 1'b0;

  logic [2:0] state_next_s;
  logic [4:0] rem_next_s;
  logic [7:0] wait_next_s;
  logic [4:0] rem_after_s;
  logic [7:0] wait_inc_s;

  // Units left once the currently presented coin is taken.
  always_comb begin
    rem_after_s = remaining_r - coin_value(coin_sel(remaining_r));
    wait_inc_s  = wait_r + 8'd1;
  end

  // Next-state, remaining and wait-counter logic.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = remaining_r;
    wait_next_s  = wait_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          rem_next_s   = amount;
          wait_next_s  = 8'd0;
          state_next_s = (amount != 5'd0) ? PRESENT : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESENT: begin
        if (coin_ack) begin
          rem_next_s   = rem_after_s;
          wait_next_s  = 8'd0;
          state_next_s = (rem_after_s == 5'd0) ? DONE : GAP;
        end else begin
          wait_next_s  = wait_inc_s;
          state_next_s = (wait_inc_s == TIMEOUT_C) ? FAULT : PRESENT;
        end
      end
      GAP: begin
        // Counter restarts for the next coin presentation.
        wait_next_s  = 8'd0;
        state_next_s = PRESENT;
      end
      DONE: begin
        state_next_s = IDLE;
      end
      FAULT: begin
        state_next_s = FAULT;
      end
      default: begin
        // Unreachable encoding: recover to a clean idle state.
        state_next_s = IDLE;
        rem_next_s   = 5'd0;
        wait_next_s  = 8'd0;
      end
    endcase
  end

  // State registers; outputs are registered from the next-state decode so
  // they line up with the state they describe and never glitch.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_r      <= IDLE;
      remaining_r  <= 5'd0;
      wait_r       <= 8'd0;
      coin_valid_r <= 1'b0;
      coin_type_r  <= 2'b00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      remaining_r  <= rem_next_s;
      wait_r       <= wait_next_s;
      coin_valid_r <= (state_next_s == PRESENT);
      coin_type_r  <= coin_sel(rem_next_s);
      busy_r       <= (state_next_s != IDLE);
      done_r       <= (state_next_s == DONE);
      fault_r      <= (state_next_s == FAULT);
    end
  end

  assign coin_valid = coin_valid_r;
  assign coin_type  = coin_type_r;
  assign remaining  = remaining_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] amount = 5'd0;
  logic       coin_ack = 1'b0;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic [4:0] remaining;
  logic       busy;
  logic       done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] NK = 2'b00;
  localparam logic [1:0] DM = 2'b01;
  localparam logic [1:0] QT = 2'b10;

  change_dispenser #(.ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .start      (start),
    .amount     (amount),
    .coin_ack   (coin_ack),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs, packed as {valid, type, remaining, busy, done, fault}.
  task automatic chk(input string tag, input logic cv, input logic [1:0] ct,
                     input logic [4:0] rem, input logic b, input logic d,
                     input logic f);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {coin_valid, coin_type, remaining, busy, done, fault};
    exp = {cv, ct, rem, b, d, f};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed v=%b t=%b r=%0d b=%b d=%b f=%b expected v=%b t=%b r=%0d b=%b d=%b f=%b",
             tag, obs[10], obs[9:8], obs[7:3], obs[2], obs[1], obs[0],
             exp[10], exp[9:8], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // Power-up state before any clock edge
    #1;
    chk("powerup", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    clear_n = 1'b0;
    tick();
    chk("reset", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);
    clear_n = 1'b1;
    tick();
    chk("idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=17, ack tied high: Q Q Q D with gaps
    amount = 5'd17; start = 1'b1; coin_ack = 1'b1;
    tick(); start = 1'b0;
    chk("a17 p1", 1'b1, QT, 5'd17, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 g1", 1'b0, QT, 5'd12, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 p2", 1'b1, QT, 5'd12, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 g2", 1'b0, QT, 5'd7, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 p3", 1'b1, QT, 5'd7, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 g3", 1'b0, DM, 5'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 p4", 1'b1, DM, 5'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk("a17 done", 1'b0, NK, 5'd0, 1'b1, 1'b1, 1'b0);
    coin_ack = 1'b0;
    tick(); chk("a17 idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); chk("a17 single done", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=8, ack delayed 3 cycles per coin: Q D N
    amount = 5'd8; start = 1'b1;
    tick(); start = 1'b0;
    chk("a8 q w0", 1'b1, QT, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("a8 q hold", 1'b1, QT, 5'd8, 1'b1, 1'b0, 1'b0);
    end
    coin_ack = 1'b1;
    tick(); coin_ack = 1'b0;
    chk("a8 gap1", 1'b0, DM, 5'd3, 1'b1, 1'b0, 1'b0);
    tick(); chk("a8 d w0", 1'b1, DM, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("a8 d hold", 1'b1, DM, 5'd3, 1'b1, 1'b0, 1'b0);
    end
    coin_ack = 1'b1;
    tick(); coin_ack = 1'b0;
    chk("a8 gap2", 1'b0, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk("a8 n w0", 1'b1, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("a8 n hold", 1'b1, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    end
    coin_ack = 1'b1;
    tick(); coin_ack = 1'b0;
    chk("a8 done", 1'b0, NK, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("a8 idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=0: straight to DONE, no coin
    amount = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("a0 done", 1'b0, NK, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("a0 idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=4, never acked: FAULT after 15 PRESENT cycles
    amount = 5'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("a4 present1", 1'b1, DM, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      tick(); chk("a4 waiting", 1'b1, DM, 5'd4, 1'b1, 1'b0, 1'b0);
    end
    tick(); chk("a4 fault", 1'b0, DM, 5'd4, 1'b1, 1'b0, 1'b1);
    coin_ack = 1'b1; start = 1'b1; amount = 5'd9;
    tick(); chk("a4 fault sticky", 1'b0, DM, 5'd4, 1'b1, 1'b0, 1'b1);
    coin_ack = 1'b0; start = 1'b0;
    clear_n = 1'b0;
    tick(); clear_n = 1'b1;
    chk("a4 cleared", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=6 with a start(31) during PRESENT and GAP: Q then N
    amount = 5'd6; start = 1'b1;
    tick();
    chk("a6 q", 1'b1, QT, 5'd6, 1'b1, 1'b0, 1'b0);
    amount = 5'd31;
    tick(); chk("a6 start ignored", 1'b1, QT, 5'd6, 1'b1, 1'b0, 1'b0);
    start = 1'b0; coin_ack = 1'b1;
    tick(); chk("a6 gap", 1'b0, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("a6 n", 1'b1, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    tick(); coin_ack = 1'b0;
    chk("a6 done", 1'b0, NK, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("a6 idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    // amount=10, reset while presenting the second coin
    amount = 5'd10; start = 1'b1; coin_ack = 1'b1;
    tick(); start = 1'b0;
    chk("a10 p1", 1'b1, QT, 5'd10, 1'b1, 1'b0, 1'b0);
    tick(); chk("a10 gap", 1'b0, QT, 5'd5, 1'b1, 1'b0, 1'b0);
    tick(); chk("a10 p2", 1'b1, QT, 5'd5, 1'b1, 1'b0, 1'b0);
    clear_n = 1'b0; start = 1'b1;
    tick(); chk("a10 reset", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);
    clear_n = 1'b1; start = 1'b0; coin_ack = 1'b0;
    tick(); chk("a10 no coin", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);
    amount = 5'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk("a1 n", 1'b1, NK, 5'd1, 1'b1, 1'b0, 1'b0);
    coin_ack = 1'b1;
    tick(); coin_ack = 1'b0;
    chk("a1 done", 1'b0, NK, 5'd0, 1'b1, 1'b1, 1'b0);
    tick(); chk("a1 idle", 1'b0, NK, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
